// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: sequential floating-point add/subtract with GRS rounding, specials, flags.
// Define FP_ADDSUB_ROUND_EN for round-to-nearest-even; otherwise truncation with saturating overflow.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic                     in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_data,
    output logic [3:0]               out_flags
);
    localparam int W = EXP_W + MAN_W + 1;
    localparam int M = MAN_W + 4;
    localparam int E = EXP_W + 1;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [EXP_W-1:0] E1 = 1;
    localparam logic [E-1:0] ONE = 1;
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state;
    logic [W-1:0] a, b, res;
    logic op, sx, sy, sub, rs;
    logic [E-1:0] ex;
    logic [M-1:0] mx, my;
    logic [M:0] mant;
    logic [3:0] flg;
    logic sa, sb, nan_a, nan_b, inf_a, inf_b, a_big;
    logic [EXP_W-1:0] ea_f, eb_f, ea, eb, diff;
    logic [M-1:0] ma, mb, m_small, sh;
    logic ge, inc, inexact, ovf;
    logic [M:0] sum;
    logic [MAN_W+1:0] rsum;
    logic [MAN_W:0] rm;
    logic [E-1:0] re;
    logic [W-1:0] rnd;
`ifdef FP_ADDSUB_ROUND_EN
    assign inc = mant[2] & (mant[1] | mant[0] | mant[3]);
    localparam logic [W-2:0] SAT = {EMAX, {MAN_W{1'b0}}};
`else
    assign inc = 1'b0;
    localparam logic [W-2:0] SAT = {EMAX - E1, {MAN_W{1'b1}}};
`endif
    assign in_ready = (state == IDLE) & ~rst;
    // Unpack and align: exponent field 0 behaves as exponent 1 without the hidden bit.
    always_comb begin
        sa = a[W-1];
        sb = b[W-1] ^ op;
        ea_f = a[W-2:MAN_W];
        eb_f = b[W-2:MAN_W];
        ea = (ea_f == '0) ? E1 : ea_f;
        eb = (eb_f == '0) ? E1 : eb_f;
        ma = {ea_f != '0, a[MAN_W-1:0], 3'b000};
        mb = {eb_f != '0, b[MAN_W-1:0], 3'b000};
        nan_a = (ea_f == EMAX) && (a[MAN_W-1:0] != '0);
        nan_b = (eb_f == EMAX) && (b[MAN_W-1:0] != '0);
        inf_a = (ea_f == EMAX) && (a[MAN_W-1:0] == '0);
        inf_b = (eb_f == EMAX) && (b[MAN_W-1:0] == '0);
        a_big = ea >= eb;
        diff = a_big ? ea - eb : eb - ea;
        m_small = a_big ? mb : ma;
        sh = (m_small >> diff) | {{(M-1){1'b0}}, |(m_small & ~({M{1'b1}} << diff))};
    end
    always_comb begin
        ge = mx >= my;
        sum = !sub ? {1'b0, mx} + {1'b0, my} : ge ? {1'b0, mx} - {1'b0, my} : {1'b0, my} - {1'b0, mx};
    end
    always_comb begin
        inexact = |mant[2:0];
        rsum = {1'b0, mant[M-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        rm = rsum[MAN_W+1] ? rsum[MAN_W+1:1] : rsum[MAN_W:0];
        re = ex + {{EXP_W{1'b0}}, rsum[MAN_W+1]};
        ovf = re >= {1'b0, EMAX};
        rnd = ovf ? {rs, SAT} : {rs, rm[MAN_W] ? re[EXP_W-1:0] : {EXP_W{1'b0}}, rm[MAN_W-1:0]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out_valid <= 1'b0;
            out_data <= '0;
            out_flags <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a <= in_a;
                    b <= in_b;
                    op <= in_op;
                    state <= ALIGN;
                end
                ALIGN: begin
                    flg <= '0;
                    if (nan_a | nan_b | (inf_a & inf_b & (sa != sb))) begin
                        res <= QNAN;
                        flg <= 4'b1000;
                        state <= DONE;
                    end else if (inf_a | inf_b) begin
                        res <= {inf_a ? sa : sb, EMAX, {MAN_W{1'b0}}};
                        state <= DONE;
                    end else begin
                        ex <= {1'b0, a_big ? ea : eb};
                        sx <= a_big ? sa : sb;
                        sy <= a_big ? sb : sa;
                        mx <= a_big ? ma : mb;
                        my <= sh;
                        sub <= sa ^ sb;
                        state <= ADD;
                    end
                end
                ADD: begin
                    mant <= sum;
                    rs <= (sub && !ge) ? sy : sx;
                    // Only a same-sign add of two zeros keeps a negative zero.
                    if (sum == '0) begin
                        res <= {sub ? 1'b0 : sx, {(W-1){1'b0}}};
                        state <= DONE;
                    end else state <= NORM;
                end
                NORM: begin
                    if (mant[M]) begin
                        mant <= {1'b0, mant[M:2], mant[1] | mant[0]};
                        ex <= ex + ONE;
                        state <= ROUND;
                    end else if (mant[M-1] || ex == ONE) state <= ROUND;
                    else begin
                        mant <= {mant[M-1:0], 1'b0};
                        ex <= ex - ONE;
                    end
                end
                ROUND: begin
                    res <= rnd;
                    flg <= {1'b0, ovf, ~ovf & ~rm[MAN_W] & inexact, inexact | ovf};
                    state <= DONE;
                end
                DONE: if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data <= res;
                    out_flags <= flg;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: table-driven checks of fp_addsub_seq results, flags and latency,
// plus backpressure and mid-operation reset sequences.
module tb_fp_addsub_seq;
`ifdef FP_ADDSUB_ROUND_EN
    localparam bit RE = 1'b1;
`else
    localparam bit RE = 1'b0;
`endif
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] y;
        logic [3:0]  f;
        int          lat;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, in_op = 1'b0;
    logic out_valid, out_ready = 1'b0;
    logic [31:0] in_a = '0, in_b = '0, out_data;
    logic [3:0] out_flags;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    vec_t v[21];
    vec_t sb_q[$];
    fp_addsub_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask
    task automatic run(input vec_t t, input int idx);
        int k;
        bit seen;
        vec_t e;
        @(negedge clk);
        in_a = t.a; in_b = t.b; in_op = t.op; in_valid = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        in_valid = 1'b0;
        sb_q.push_back(t);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            seen = out_valid;
        end
        e = sb_q.pop_front();
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL v%0d timeout: out_valid never rose", idx);
        end else begin
            chk($sformatf("v%0d data", idx), out_data, e.y);
            chk($sformatf("v%0d flags", idx), 32'(out_flags), 32'(e.f));
            chk($sformatf("v%0d latency", idx), 32'(cyc - k), 32'(e.lat));
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk($sformatf("v%0d handshake", idx), 32'({in_ready, out_valid}), 32'(2'b10));
        end
    endtask
    initial begin
        bit seen;
        int extra;
        v[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0, 5};
        v[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0, 3};
        v[2]  = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'h0, 29};
        v[3]  = '{32'h3F800000, 32'h34400000, 1'b0, RE ? 32'h3F800002 : 32'h3F800001, 4'h1, 5};
        v[4]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8, 2};
        v[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RE ? 32'h7F800000 : 32'h7F7FFFFF, 4'h5, 5};
        v[6]  = '{32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 4'h0, 5};
        v[7]  = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'h0, 6};
        v[8]  = '{32'hFFC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8, 2};
        v[9]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'h0, 2};
        v[10] = '{32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'h0, 2};
        v[11] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0, 3};
        v[12] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0, 3};
        v[13] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8, 2};
        v[14] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 4'h0, 5};
        v[15] = '{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'h1, 5};
        v[16] = '{32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 4'h0, 6};
        v[17] = '{32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 4'h0, 6};
        v[18] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1, 5};
        v[19] = '{32'h7F000000, 32'h7F000000, 1'b0, RE ? 32'h7F800000 : 32'h7F7FFFFF, 4'h5, 5};
        v[20] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, RE ? 32'h40000000 : 32'h3FFFFFFF, 4'h1, 5};
        @(negedge clk); @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset out_flags", 32'(out_flags), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 21; i++) run(v[i], i);
        // Backpressure: result held, busy, extra operands ignored.
        @(negedge clk);
        in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            seen = out_valid;
        end
        chk("bp out_valid", 32'(seen), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_a = 32'h40000000; in_b = 32'h40000000; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("bp data %0d", i), out_data, 32'h40400000);
            chk($sformatf("bp in_ready %0d", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp valid held %0d", i), 32'(out_valid), 32'd1);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("bp ignored pulse", 32'(extra), 32'd0);
        // Reset while normalising the long cancellation case.
        @(negedge clk);
        in_a = 32'h3F800000; in_b = 32'h3F7FFFFF; in_op = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready low", 32'(in_ready), 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst in_ready back", 32'(in_ready), 32'd1);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("rst aborted", 32'(extra), 32'd0);
        run(v[0], 100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_addsub_seq.md
# fp_addsub_seq

Sequential, parametrised IEEE-754-style floating-point adder/subtractor. It is the successor to the single-precision combinational adder and sits between operand registers and the result consumer in the lab datapath. Compared with that adder it adds:
- generic exponent/mantissa widths;
- a subtract mode;
- valid/ready handshakes on both sides;
- guard/round/sticky rounding, special-value handling and exception flags;
- iterative (one bit per cycle) normalisation driven by an FSM.

## Interface
- EXP_W, default 8: exponent field width.
- MAN_W, default 23: stored fraction width (hidden bit not stored).
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept operands.
- in_a, in_b  in  EXP_W+MAN_W+1  operands {sign, exp, frac}.
- in_op  in  1  0 = a+b, 1 = a−b (sign of b inverted).
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  EXP_W+MAN_W+1  result.
- out_flags  out  4  {invalid, overflow, underflow, inexact}.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture in_a, in_b and in_op, then go to ALIGN.
  - ALIGN: unpack both operands. Exp field 0 is treated as exp 1 with hidden bit 0.
    - Specials resolve here and go straight to DONE:
      - any NaN → 0x7FC00000-style canonical qNaN (sign 0, frac MSB 1), invalid=1;
      - +Inf + −Inf (after op) → qNaN, invalid=1;
      - Inf + finite → that Inf.
    - Otherwise, right-shift the smaller-exponent mantissa by the exponent difference into MAN_W+4 bits: hidden, frac, G, R, S, with S = OR of all bits shifted out. A difference > MAN_W+3 leaves only the sticky bit.
  - ADD: add or subtract magnitudes into MAN_W+5 bits (carry included), larger magnitude minus smaller. Sign is taken from the larger magnitude.
    - Exact zero → +0, except (−0)+(−0) → −0. Zero results go to DONE.
  - NORM, evaluated once per cycle:
    - if carry set: shift right 1 (sticky absorbs the shifted-out bit), exp+1, go to ROUND;
    - else if hidden bit set or exp==1: go to ROUND;
    - else: shift left 1, exp−1, stay in NORM.
  - ROUND: round-to-nearest-even using G/R/S (see Configuration).
    - A mantissa carry out renormalises with exp+1.
    - exp ≥ all-ones → ±Inf, overflow=1, inexact=1.
    - Hidden bit 0 at exp 1 → exp field 0 (subnormal). If inexact, set underflow=1.
    - inexact = G|R|S before rounding.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Only one operation is in flight at a time. Operands are not accepted in any state other than IDLE.

## Timing
- Reset values: state IDLE, out_valid=0, out_data=0, out_flags=0.
- in_ready = (state==IDLE) & ~rst. It is 0 in the cycle rst is high.
- Latency, with the accept edge at cycle k and L = number of NORM left shifts (0 ≤ L ≤ MAN_W+1):
  - normal result: out_valid rises at edge k+5+L;
  - special-value result: k+2;
  - exact-zero result: k+3.
- out_data and out_flags are registered. They are stable while out_valid=1 and out_ready=0.
- Handshake completes at the edge where out_valid & out_ready. in_ready returns 1 on the next cycle; there is no same-cycle turnaround.
- rst asserted in any state aborts the operation at that edge. No result is produced and all outputs take their reset values.
- in_valid seen in any state other than IDLE is ignored.

## Configuration
- FP_ADDSUB_ROUND_EN:
  - defined: round-to-nearest-even, i.e. increment when G & (R|S|LSB);
  - undefined: truncation (round toward zero). The increment logic is removed, and overflow saturates to the largest finite value, not Inf.
- inexact and underflow are reported identically in both builds.

## Test plan
All values use defaults (EXP_W=8, MAN_W=23).
- 0x3F800000 + 0x40000000, op=0 → 0x40400000, flags 0, out_valid at k+5.
- 0x3F800000 − 0x3F800000 (op=1) → 0x00000000. Then 0x3F800000 − 0x3F7FFFFF → 0x33800000, flags 0, L=24, out_valid at k+29.
- Rounding: 0x3F800000 + 0x34400000 → 0x3F800002 with ROUND_EN, 0x3F800001 without. inexact=1 in both builds.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, invalid=1, out_valid at k+2;
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 (ROUND_EN) or 0x7F7FFFFF (without), overflow=1.
- Subnormal: 0x00400000 + 0x00400000 → 0x00800000, flags 0.
- Backpressure/reset:
  - hold out_ready=0 for 3 cycles: out_data constant, in_ready=0, and a second in_valid pulse is ignored;
  - assert rst during NORM: next cycle out_valid=0, in_ready=1 after rst drops.
